// File: rtl/ahb_ram_pkg.sv
// ahb_ram_pkg: AHB transfer/size codes, error-FSM states and the strobe/alignment helpers
package ahb_ram_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} err_state_t;
    function automatic logic [3:0] ahb_strb(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a :
               size == HSIZE_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction
    function automatic logic ahb_misaligned(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_HALF ? a[0] : size == HSIZE_WORD ? |a : size > HSIZE_WORD;
    endfunction
endpackage

// File: rtl/ahb_ram_ctrl_if.sv
// ahb_ram_ctrl_if: AHB-Lite slave-side signal bundle with master/slave views
interface ahb_ram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_ram_fwd.sv
// ahb_ram_fwd: captures write data for a read that follows a same-word write and merges it onto HRDATA
module ahb_ram_fwd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hit,
    input  logic [3:0]  strb,
    input  logic [31:0] wdata,
    input  logic        rd_pend,
    input  logic [31:0] ram_doutb,
    output logic [31:0] hrdata
);
    logic        fwd_hit;
    logic [3:0]  fwd_strb;
    logic [31:0] fwd_data;
    // hold the in-flight write bytes for the read's data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_strb <= 4'b0000;
            fwd_data <= 32'h0;
        end else if (load) begin
            fwd_hit  <= hit;
            fwd_strb <= strb;
            fwd_data <= wdata;
        end
    end
    // per-byte select between forwarded write data and the RAM's pre-write word
    always_comb begin
        hrdata = 32'h0;
        for (int i = 0; i < 4; i++)
            hrdata[8*i +: 8] = !rd_pend ? 8'h00 :
                               fwd_hit && fwd_strb[i] ? fwd_data[8*i +: 8] : ram_doutb[8*i +: 8];
    end
endmodule

// File: rtl/ahb_ram_ctrl.sv
// ahb_ram_ctrl: zero-wait AHB-Lite slave for a simple dual-port RAM; AHB_RAM_ALIGN_CHK_EN adds misalignment ERROR responses
module ahb_ram_ctrl
    import ahb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_ram_ctrl_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);
    logic                  acc, bad, acc_ok;
    logic                  wr_pend, rd_pend;
    logic [ADDR_WIDTH-1:0] waddr, addr_q;
    logic [3:0]            strb, strb_q;
    logic [31:0]           hrdata;
    logic                  unused_bits;

    assign acc         = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign acc_ok      = acc & ~bad;
    assign waddr       = bus.HADDR[ADDR_WIDTH+1:2];
    assign strb        = ahb_strb(bus.HSIZE, bus.HADDR[1:0]);
    assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

    // register the accepted address phase for its data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            addr_q  <= '0;
            strb_q  <= 4'b0000;
        end else if (bus.HREADY) begin
            wr_pend <= acc_ok & bus.HWRITE;
            rd_pend <= acc_ok & ~bus.HWRITE;
            if (acc_ok) begin
                addr_q <= waddr;
                strb_q <= strb;
            end
        end
    end

    assign ram_addra = addr_q;
    assign ram_dina  = bus.HWDATA;
    assign ram_wea   = wr_pend ? strb_q : 4'b0000;
    assign ram_addrb = waddr;

    ahb_ram_fwd u_fwd (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .load      (bus.HREADY),
        .hit       (acc_ok & ~bus.HWRITE & wr_pend & (addr_q == waddr)),
        .strb      (strb_q),
        .wdata     (bus.HWDATA),
        .rd_pend   (rd_pend),
        .ram_doutb (ram_doutb),
        .hrdata    (hrdata)
    );
    assign bus.HRDATA = hrdata;

`ifdef AHB_RAM_ALIGN_CHK_EN
    err_state_t state;
    logic       hreadyout_q, hresp_q;
    assign bad = acc & ahb_misaligned(bus.HSIZE, bus.HADDR[1:0]);
    // two-cycle ERROR response for misaligned transfers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state)
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    state       <= bad ? ST_ERR1 : ST_OKAY;
                    hreadyout_q <= ~bad;
                    hresp_q     <= bad;
                end
            endcase
        end
    end
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
`else
    assign bad           = 1'b0;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// tb_ahb_ram_ctrl: directed bench for ahb_ram_ctrl with a read-first dual-port RAM model
module tb_ahb_ram_ctrl;
    import ahb_ram_pkg::*;
    localparam int AW = 14;
    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_dina, ram_doutb;
    logic [3:0]    ram_wea;
    logic [31:0]   mem [0:(1<<AW)-1];
    int            errors = 0;
    int            checks = 0;

    ahb_ram_ctrl_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    always #5 HCLK = ~HCLK;

    // RAM model: preset pattern, read-first registered read, byte-enabled write
    initial begin
        logic [31:0] old;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | 32'(i);
        ram_doutb = 32'h0;
        forever begin
            @(posedge HCLK);
            old = mem[ram_addrb];
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) mem[ram_addra][8*b +: 8] = ram_dina[8*b +: 8];
            ram_doutb <= old;
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic [2:0] sz, input logic w, input logic [31:0] wd);
        bus.HSEL   = sel;
        bus.HTRANS = tr;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HWRITE = w;
        bus.HWDATA = wd;
    endtask

    task automatic test_reset;
        drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        HRESETn = 1'b0;
        #3;
        checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", bus.HREADYOUT); end
        checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b exp 0", bus.HRESP); end
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL rst_wea got %b exp 0000", ram_wea); end
        checks++; if (ram_addra !== 14'h0) begin errors++; $display("FAIL rst_addra got %h exp 0", ram_addra); end
        repeat (2) tick;
        HRESETn = 1'b1;
    endtask

    task automatic test_word;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h100, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'hDEADBEEF);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b1111) begin errors++; $display("FAIL word_wea got %b exp 1111", ram_wea); end
        checks++; if (ram_addra !== 14'h40) begin errors++; $display("FAIL word_addra got %h exp 0040", ram_addra); end
        checks++; if (ram_dina !== 32'hDEADBEEF) begin errors++; $display("FAIL word_dina got %h exp deadbeef", ram_dina); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h100, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL idle_wea got %b exp 0000", ram_wea); end
        checks++; if (ram_addrb !== 14'h40) begin errors++; $display("FAIL word_addrb got %h exp 0040", ram_addrb); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd got %h exp deadbeef", bus.HRDATA); end
        checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL word_rd_ready got %b exp 1", bus.HREADYOUT); end
    endtask

    task automatic test_bytes;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h201, HSIZE_BYTE, 1'b1, 32'h0);
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h202, HSIZE_HALF, 1'b1, 32'h00005500);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b0010) begin errors++; $display("FAIL byte_wea got %b exp 0010", ram_wea); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'hA5A50000);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b1100) begin errors++; $display("FAIL half_wea got %b exp 1100", ram_wea); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h200, HSIZE_WORD, 1'b0, 32'h0);
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hA5A55580) begin errors++; $display("FAIL bytes_rd got %h exp a5a55580", bus.HRDATA); end
    endtask

    task automatic test_back_to_back;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h300, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h300, HSIZE_WORD, 1'b0, 32'h11223344);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b1111) begin errors++; $display("FAIL b2b_wea got %b exp 1111", ram_wea); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h301, HSIZE_BYTE, 1'b1, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'h11223344) begin errors++; $display("FAIL fwd_word got %h exp 11223344", bus.HRDATA); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h300, HSIZE_WORD, 1'b0, 32'hAAAAFFAA);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b0010) begin errors++; $display("FAIL fwd_byte_wea got %b exp 0010", ram_wea); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'h1122FF44) begin errors++; $display("FAIL fwd_byte got %h exp 1122ff44", bus.HRDATA); end
    endtask

    task automatic test_no_fwd;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h400, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h404, HSIZE_WORD, 1'b0, 32'h12345678);
        @(negedge HCLK);
        checks++; if (ram_addra !== 14'h100) begin errors++; $display("FAIL nofwd_addra got %h exp 0100", ram_addra); end
        checks++; if (ram_addrb !== 14'h101) begin errors++; $display("FAIL nofwd_addrb got %h exp 0101", ram_addrb); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h400, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hC0DE0101) begin errors++; $display("FAIL nofwd_rd got %h exp c0de0101", bus.HRDATA); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h00010100, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'h12345678) begin errors++; $display("FAIL nofwd_back got %h exp 12345678", bus.HRDATA); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_rd got %h exp deadbeef", bus.HRDATA); end
    endtask

    task automatic test_idle;
        tick; drive(1'b1, HTRANS_BUSY, 32'h600, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b0, HTRANS_NONSEQ, 32'h600, HSIZE_WORD, 1'b1, 32'hFFFFFFFF);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL busy_wea got %b exp 0000", ram_wea); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'hFFFFFFFF);
        @(negedge HCLK);
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL nosel_wea got %b exp 0000", ram_wea); end
    endtask

    task automatic test_reset_mid_write;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h500, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'hBADBAD00);
        #1;
        checks++; if (ram_wea !== 4'b1111) begin errors++; $display("FAIL rstw_pre_wea got %b exp 1111", ram_wea); end
        HRESETn = 1'b0;
        #1;
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL rstw_wea got %b exp 0000", ram_wea); end
        checks++; if (ram_addra !== 14'h0) begin errors++; $display("FAIL rstw_addra got %h exp 0", ram_addra); end
        tick;
        HRESETn = 1'b1;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h500, HSIZE_WORD, 1'b0, 32'h0);
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRDATA !== 32'hC0DE0140) begin errors++; $display("FAIL rstw_rd got %h exp c0de0140", bus.HRDATA); end
        checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL rstw_hresp got %b exp 0", bus.HRESP); end
    endtask

`ifdef AHB_RAM_ALIGN_CHK_EN
    task automatic test_align;
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h102, HSIZE_WORD, 1'b1, 32'h0);
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h55555555);
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b0) begin errors++; $display("FAIL err1_ready got %b exp 0", bus.HREADYOUT); end
        checks++; if (bus.HRESP !== 1'b1) begin errors++; $display("FAIL err1_resp got %b exp 1", bus.HRESP); end
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL err1_wea got %b exp 0000", ram_wea); end
        tick; drive(1'b1, HTRANS_NONSEQ, 32'h100, HSIZE_WORD, 1'b0, 32'h55555555);
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL err2_ready got %b exp 1", bus.HREADYOUT); end
        checks++; if (bus.HRESP !== 1'b1) begin errors++; $display("FAIL err2_resp got %b exp 1", bus.HRESP); end
        checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL err2_wea got %b exp 0000", ram_wea); end
        tick; drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge HCLK);
        checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL align_ok_resp got %b exp 0", bus.HRESP); end
        checks++; if (bus.HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL align_ok_rd got %h exp deadbeef", bus.HRDATA); end
    endtask
`endif

    initial begin
        test_reset;
        test_word;
        test_bytes;
        test_back_to_back;
        test_no_fwd;
        test_idle;
        test_reset_mid_write;
`ifdef AHB_RAM_ALIGN_CHK_EN
        test_align;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_ram_ctrl.md
Name: ahb_ram_ctrl

Overview:
- AHB-Lite slave that sequences the MCU's simple dual-port block RAM: one write port with per-byte enables, one read port with a registered read and 1-cycle latency.
- Maps Cortex-M0 address and data phases onto the RAM's separate write and read ports with zero wait states.
- Generates byte strobes from HSIZE/HADDR.
- Forwards write data into a read that immediately follows a write to the same word.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width; RAM size is 2^ADDR_WIDTH x 32 bits; word address = HADDR[ADDR_WIDTH+1:2].

Ports:
- HCLK  in  1  system clock; RAM shares it.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ (active).
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWRITE  in  1  1=write.
- HREADY  in  1  bus-wide ready; an address phase is accepted only when HREADY=1.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- ram_addra  out  ADDR_WIDTH  RAM write word address.
- ram_dina  out  32  RAM write data (= HWDATA).
- ram_wea  out  4  RAM byte write enables.
- ram_addrb  out  ADDR_WIDTH  RAM read word address (= HADDR[ADDR_WIDTH+1:2], combinational).
- ram_doutb  in  32  RAM read data, valid 1 cycle after ram_addrb.

Behaviour:
- Accept condition: acc = HSEL & HTRANS[1] & HREADY.
- On acc, register for the data phase: wr_pend=HWRITE, rd_pend=~HWRITE, word address, and byte strobe strb.
- strb rule:
  - byte: 4'b0001<<HADDR[1:0]
  - half: 4'b0011<<{HADDR[1],1'b0}
  - word or HSIZE>2: 4'b1111
- Write data phase: ram_wea=strb when wr_pend, else 4'b0; ram_addra=registered word address; ram_dina=HWDATA. The RAM commits at the edge ending the data phase.
- Read: ram_addrb is driven from HADDR every cycle. In the read data phase (rd_pend), HRDATA=ram_doutb, so read latency equals the AHB data phase and there are no wait states.
- RAW hazard: the address phase of a read coincides with the data phase of a write to the same word. The RAM then returns the pre-write word.
  - On acc of that read, register fwd_hit=wr_pend & (word address match), fwd_strb=strb and fwd_data=HWDATA.
  - Next cycle, each HRDATA byte i = fwd_hit&fwd_strb[i] ? fwd_data byte i : ram_doutb byte i.
- Write followed by read of a different word: no forwarding.
- Back-to-back writes pipeline with no stall.
- IDLE/BUSY or HSEL=0 clears wr_pend/rd_pend/fwd_hit at the next accepted phase. ram_wea must be 0 when no write data phase is active.
- HREADYOUT=1 and HRESP=0 in all cases except the optional error path.
- Reset (async, HRESETn=0): wr_pend=0, rd_pend=0, fwd_hit=0, registered address/strb=0, so ram_wea=0 and ram_addra=0; HREADYOUT=1, HRESP=0.
  - Reset asserted mid-write data phase: the write is dropped (ram_wea forced 0 immediately).
- Address bits above ADDR_WIDTH+1 are ignored; accesses wrap modulo RAM size.

Optional Feature:
- AHB_RAM_ALIGN_CHK_EN defined: misaligned access (half with HADDR[0]=1, word with HADDR[1:0]!=0, or HSIZE>2) gets a two-cycle ERROR response.
  - FSM states: OKAY -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> OKAY.
  - No RAM write is issued and wr_pend is not set; HRDATA is don't-care.
  - A new acc during ERR2 is accepted normally.
- Undefined: no check; strobes follow the strb rule above; HRESP is tied 0.

Decomposition:
- Package ahb_ram_pkg: HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE codes, error-FSM state encoding, and the strobe-generation function.
- One sub-module, ahb_ram_fwd: holds fwd_hit/fwd_strb/fwd_data and performs the byte merge onto HRDATA.

Test Plan:
- Reset -> HREADYOUT=1, HRESP=0, ram_wea=0. Word write 0x100=0xDEADBEEF, then read 0x100 after an idle -> HRDATA=0xDEADBEEF, zero wait states.
- Byte writes 0x55 to 0x201, then half write 0xA5A5 to 0x202 -> ram_wea 4'b0010 then 4'b1100. Read 0x200 -> 0xA5A555xx, where xx is the prior byte 0.
- Back-to-back write 0x300=0x11223344, then read 0x300 in the next address phase -> HRDATA=0x11223344 via forwarding. Same with a byte write 0xFF to 0x301 -> merged byte 1 only.
- Write 0x400 then immediately read 0x404 -> no forwarding; HRDATA = stored 0x404 contents.
- HRESETn pulsed low during a write data phase -> ram_wea drops to 0 asynchronously; the target word is unchanged on read-back.
- With AHB_RAM_ALIGN_CHK_EN: word write to 0x102 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, ram_wea stays 0. Following aligned read gets an OKAY response.
